// File: rtl/m_cache_refill_pkg.sv
// rtl/m_cache_refill_pkg.sv - shared state encoding, line geometry and address helpers for the refill engine
`ifndef EADDR_WIDTH
`define EADDR_WIDTH 32
`endif

package m_cache_refill_pkg;

  localparam int EADDR_W          = `EADDR_WIDTH;
  localparam int LINE_WORDS       = 4;
  localparam int WORD_OFFSET_BITS = 2;
  // byte offset within a line: word index plus byte-in-word
  localparam int LINE_OFFSET_BITS = WORD_OFFSET_BITS + 2;

  localparam logic [EADDR_W-1:0] LINE_BASE_MASK =
    {{(EADDR_W-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DRAIN   = 2'd2,
    S_INSTALL = 2'd3
  } refill_state_e;

  // holds 0..LINE_WORDS inclusive
  typedef logic [2:0] word_cnt_t;

  function automatic logic [EADDR_W-1:0] line_base(input logic [EADDR_W-1:0] addr);
    return addr & LINE_BASE_MASK;
  endfunction

  // word address inside the line; never carries into the line base
  function automatic logic [EADDR_W-1:0] word_addr(input logic [EADDR_W-1:0] base,
                                                   input logic [WORD_OFFSET_BITS-1:0] idx);
    return {base[EADDR_W-1:LINE_OFFSET_BITS], idx, 2'b00};
  endfunction

endpackage

// File: rtl/m_cache_refill_timer.sv
// rtl/m_cache_refill_timer.sv - loadable down-counter flagging a stalled memory response
module m_refill_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  // remaining stalled cycles after the current one; the abort pulse is
  // registered, so expiry is flagged one cycle ahead of the TIMEOUT-th stall
  logic [CW-1:0] count;

  // reload on every bit of progress, otherwise count down while waiting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_load) begin
      count <= CW'(TIMEOUT - 1);
    end else if (i_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign o_expire = i_en && (count <= CW'(1));

endmodule

// File: rtl/m_cache_refill.sv
// rtl/m_cache_refill.sv - fetches a 4-word cache line from memory and installs it into the cache
module m_cache_refill
  import m_cache_refill_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_miss,
  input  logic [EADDR_W-1:0]        i_maddr,
  input  logic                      i_cpu_we,
  output logic                      o_busy,
  output logic                      o_mem_req,
  output logic [EADDR_W-1:0]        o_mem_addr,
  input  logic                      i_mem_gnt,
  input  logic                      i_mem_rvalid,
  input  logic [31:0]               i_mem_rdata,
  output logic                      o_ie,
  output logic [EADDR_W-1:0]        o_iaddr,
  output logic [LINE_WORDS*32-1:0]  o_idata,
  output logic                      o_done,
  output logic                      o_err
);

  refill_state_e             state;
  logic [EADDR_W-1:0]        base;
  word_cnt_t                 issue_cnt;
  word_cnt_t                 recv_cnt;
  logic [LINE_WORDS*32-1:0]  line;
  logic                      abort_q;

  logic      active;
  logic      start;
  logic      gnt_take;
  logic      rsp_take;
  logic      progress;
  logic      expire;
  logic      abort;
  word_cnt_t issue_nxt;
  word_cnt_t recv_nxt;

  // a response counts against grants including one landing this same cycle
  always_comb begin
    active    = (state == S_FETCH) || (state == S_DRAIN);
    start     = (state == S_IDLE) && i_miss;
    gnt_take  = (state == S_FETCH) && i_mem_gnt;
    issue_nxt = issue_cnt + {2'b00, gnt_take};
    rsp_take  = active && i_mem_rvalid && (recv_cnt < issue_nxt);
    recv_nxt  = recv_cnt + {2'b00, rsp_take};
    progress  = gnt_take || rsp_take;
    abort     = active && expire && !progress;
  end

  m_refill_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (start || progress),
    .i_en     (active),
    .o_expire (expire)
  );

  // refill sequencer: issue four reads, collect four words, install the line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      line      <= '0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base      <= line_base(i_maddr);
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= S_FETCH;
          end
        end
        S_FETCH, S_DRAIN: begin
          issue_cnt <= issue_nxt;
          recv_cnt  <= recv_nxt;
          if (rsp_take) begin
            line[{recv_cnt[1:0], 5'b00000} +: 32] <= i_mem_rdata;
          end
          if (abort) begin
            state   <= S_IDLE;
            abort_q <= 1'b1;
          end else if (recv_nxt == 3'd4) begin
            state <= S_INSTALL;
          end else if (issue_nxt == 3'd4) begin
            state <= S_DRAIN;
          end
        end
        S_INSTALL: begin
          if (!i_cpu_we) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // install waits on the cache's own write port, so o_ie follows i_cpu_we directly
  assign o_busy     = (state != S_IDLE);
  assign o_mem_req  = (state == S_FETCH);
  assign o_mem_addr = word_addr(base, issue_cnt[1:0]);
  assign o_ie       = (state == S_INSTALL) && !i_cpu_we;
  assign o_iaddr    = base;
  assign o_idata    = line;
  assign o_done     = o_ie || abort_q;
  assign o_err      = abort_q;

endmodule

// File: tb/tb_m_cache_refill.sv
// tb/tb_m_cache_refill.sv - directed self-checking bench for m_cache_refill
module tb_m_cache_refill;
  import m_cache_refill_pkg::*;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_miss;
  logic [EADDR_W-1:0] i_maddr;
  logic               i_cpu_we;
  logic               o_busy;
  logic               o_mem_req;
  logic [EADDR_W-1:0] o_mem_addr;
  logic               i_mem_gnt;
  logic               i_mem_rvalid;
  logic [31:0]        i_mem_rdata;
  logic               o_ie;
  logic [EADDR_W-1:0] o_iaddr;
  logic [127:0]       o_idata;
  logic               o_done;
  logic               o_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  m_cache_refill #(
    .TIMEOUT (8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_miss       (i_miss),
    .i_maddr      (i_maddr),
    .i_cpu_we     (i_cpu_we),
    .o_busy       (o_busy),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_ie         (o_ie),
    .o_iaddr      (o_iaddr),
    .o_idata      (o_idata),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  task automatic drive(input logic miss, input logic [EADDR_W-1:0] addr, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic we);
    i_miss       = miss;
    i_maddr      = addr;
    i_mem_gnt    = gnt;
    i_mem_rvalid = rv;
    i_mem_rdata  = rd;
    i_cpu_we     = we;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  // cycle 0 miss, cycles 1..4 grant+response together; returns at start of cycle 5
  task automatic fast_fetch(input logic [EADDR_W-1:0] addr, input logic [31:0] d0);
    drive(1'b1, addr, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, d0 + 32'(k), 1'b0);
      next_cycle();
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive(1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_cmp++; if ({o_busy, o_mem_req, o_ie, o_done, o_err} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {o_busy, o_mem_req, o_ie, o_done, o_err}); end
    n_cmp++; if (o_mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
    n_cmp++; if (o_iaddr !== 32'h0 || o_idata !== 128'h0) begin n_bad++; $display("FAIL reset_install: got %h/%h want 0/0", o_iaddr, o_idata); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    i_rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_min_latency();
    logic [127:0]       exp_line;
    logic [EADDR_W-1:0] ea;
    exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge i_clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL min_idle_busy: got %b want 0", o_busy); end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hA0 + 32'(k), 1'b0);
      ea = 32'h0000_1230 + 32'(4 * k);
      @(negedge i_clk);
      n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== ea) begin n_bad++; $display("FAIL min_req[%0d]: got %b/%h want 1/%h", k, o_mem_req, o_mem_addr, ea); end
      n_cmp++; if (o_ie !== 1'b0 || o_busy !== 1'b1) begin n_bad++; $display("FAIL min_busy[%0d]: got ie=%b busy=%b want 0/1", k, o_ie, o_busy); end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge i_clk);
    n_cmp++; if ({o_ie, o_done, o_err, o_mem_req} !== 4'b1100) begin n_bad++; $display("FAIL min_install_flags: got %b want 1100", {o_ie, o_done, o_err, o_mem_req}); end
    n_cmp++; if (o_iaddr !== 32'h0000_1230) begin n_bad++; $display("FAIL min_iaddr: got %h want 00001230", o_iaddr); end
    n_cmp++; if (o_idata !== exp_line) begin n_bad++; $display("FAIL min_idata: got %h want %h", o_idata, exp_line); end
    next_cycle();
    @(negedge i_clk);
    n_cmp++; if (o_ie !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL min_after: got ie=%b busy=%b want 0/0", o_ie, o_busy); end
    next_cycle();
  endtask

  task automatic test_delayed();
    logic [127:0]       exp_line;
    logic [EADDR_W-1:0] ea;
    logic               gnt;
    logic               rv;
    int                 ie_cnt;
    exp_line = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    ie_cnt = 0;
    drive(1'b1, 32'h0000_2238, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    for (int c = 1; c <= 12; c++) begin
      gnt = (c == 1) || (c == 3) || (c == 5) || (c == 7);
      rv  = (c == 4) || (c == 6) || (c == 8) || (c == 10);
      drive(1'b0, 32'h0, gnt, rv, rv ? 32'hB0 + 32'((c - 4) / 2) : 32'h0, 1'b0);
      @(negedge i_clk);
      if (gnt) begin
        ea = 32'h0000_2230 + 32'(4 * ((c - 1) / 2));
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== ea) begin n_bad++; $display("FAIL dly_addr[c%0d]: got %b/%h want 1/%h", c, o_mem_req, o_mem_addr, ea); end
      end
      if (c == 8) begin
        n_cmp++; if (o_mem_req !== 1'b0 || o_busy !== 1'b1) begin n_bad++; $display("FAIL dly_drain: got req=%b busy=%b want 0/1", o_mem_req, o_busy); end
      end
      if (c == 11) begin
        n_cmp++; if (o_ie !== 1'b1 || o_idata !== exp_line) begin n_bad++; $display("FAIL dly_install: got %b/%h want 1/%h", o_ie, o_idata, exp_line); end
      end
      if (o_ie === 1'b1) ie_cnt++;
      next_cycle();
    end
    n_cmp++; if (ie_cnt !== 1) begin n_bad++; $display("FAIL dly_ie_count: got %0d want 1", ie_cnt); end
  endtask

  task automatic test_cpu_we();
    logic [127:0] exp_line;
    exp_line = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    fast_fetch(32'h0000_300C, 32'hC0);
    for (int c = 5; c <= 10; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      @(negedge i_clk);
      n_cmp++; if ({o_ie, o_done, o_busy} !== 3'b001) begin n_bad++; $display("FAIL we_hold[c%0d]: got %b want 001", c, {o_ie, o_done, o_busy}); end
      n_cmp++; if (o_idata !== exp_line) begin n_bad++; $display("FAIL we_line[c%0d]: got %h want %h", c, o_idata, exp_line); end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge i_clk);
    n_cmp++; if ({o_ie, o_done} !== 2'b11 || o_iaddr !== 32'h0000_3000) begin n_bad++; $display("FAIL we_release: got %b/%h want 11/00003000", {o_ie, o_done}, o_iaddr); end
    n_cmp++; if (o_idata !== exp_line) begin n_bad++; $display("FAIL we_release_line: got %h want %h", o_idata, exp_line); end
    next_cycle();
  endtask

  task automatic test_timeout();
    logic [127:0] exp_line;
    int           ie_cnt;
    ie_cnt = 0;
    drive(1'b1, 32'h0000_4004, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    for (int c = 1; c <= 13; c++) begin
      drive(1'b0, 32'h0, (c <= 4), (c <= 3) || (c == 13),
            (c == 13) ? 32'hDEAD_0000 : 32'hE0 + 32'(c - 1), 1'b0);
      @(negedge i_clk);
      if (c < 12) begin
        n_cmp++; if ({o_done, o_err, o_busy} !== 3'b001) begin n_bad++; $display("FAIL tmo_wait[c%0d]: got %b want 001", c, {o_done, o_err, o_busy}); end
      end else if (c == 12) begin
        n_cmp++; if ({o_done, o_err, o_busy} !== 3'b110) begin n_bad++; $display("FAIL tmo_abort: got %b want 110", {o_done, o_err, o_busy}); end
      end else begin
        n_cmp++; if ({o_done, o_err, o_busy} !== 3'b000) begin n_bad++; $display("FAIL tmo_after: got %b want 000", {o_done, o_err, o_busy}); end
      end
      if (o_ie === 1'b1) ie_cnt++;
      next_cycle();
    end
    n_cmp++; if (ie_cnt !== 0) begin n_bad++; $display("FAIL tmo_no_install: got %0d want 0", ie_cnt); end
    exp_line = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    fast_fetch(32'h0000_4008, 32'hD0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge i_clk);
    n_cmp++; if ({o_ie, o_err} !== 2'b10 || o_iaddr !== 32'h0000_4000) begin n_bad++; $display("FAIL tmo_refill: got %b/%h want 10/00004000", {o_ie, o_err}, o_iaddr); end
    n_cmp++; if (o_idata !== exp_line) begin n_bad++; $display("FAIL tmo_refill_line: got %h want %h", o_idata, exp_line); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h0000_5010, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 32'h0, 1'b1, (c <= 2), 32'hF0 + 32'(c), 1'b0);
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge i_clk);
    n_cmp++; if (o_busy !== 1'b1 || o_mem_addr !== 32'h0000_501C) begin n_bad++; $display("FAIL rst_pre: got %b/%h want 1/0000501c", o_busy, o_mem_addr); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if ({o_busy, o_mem_req, o_ie, o_done, o_err} !== 5'b0) begin n_bad++; $display("FAIL rst_async_flags: got %b want 00000", {o_busy, o_mem_req, o_ie, o_done, o_err}); end
    n_cmp++; if (o_mem_addr !== 32'h0 || o_iaddr !== 32'h0 || o_idata !== 128'h0) begin n_bad++; $display("FAIL rst_async_data: got %h/%h/%h want 0", o_mem_addr, o_iaddr, o_idata); end
    next_cycle();
    i_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h5A5A_0000 + 32'(c), 1'b0);
      @(negedge i_clk);
      n_cmp++; if ({o_busy, o_ie, o_done} !== 3'b000 || o_idata !== 128'h0) begin n_bad++; $display("FAIL rst_stale[%0d]: got %b/%h want 000/0", c, {o_busy, o_ie, o_done}, o_idata); end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_miss_held();
    logic [127:0] exp_line;
    logic         act;
    int           ie_cnt;
    exp_line = {32'h10A, 32'h109, 32'h108, 32'h107};
    ie_cnt = 0;
    for (int c = 0; c <= 13; c++) begin
      act = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 10));
      drive((c <= 10), (c <= 4) ? 32'h0000_6004 : 32'h0000_7004, act, act, 32'h100 + 32'(c), 1'b0);
      @(negedge i_clk);
      if (c == 3) begin
        n_cmp++; if (o_mem_addr !== 32'h0000_6008) begin n_bad++; $display("FAIL held_no_restart: got %h want 00006008", o_mem_addr); end
      end
      if (c == 6) begin
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL held_idle_gap: got %b want 0", o_busy); end
      end
      if (c == 7) begin
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_7000) begin n_bad++; $display("FAIL held_second: got %b/%h want 1/00007000", o_mem_req, o_mem_addr); end
      end
      if (c == 11) begin
        n_cmp++; if (o_ie !== 1'b1 || o_iaddr !== 32'h0000_7000 || o_idata !== exp_line) begin n_bad++; $display("FAIL held_install: got %b/%h/%h want 1/00007000/%h", o_ie, o_iaddr, o_idata, exp_line); end
      end
      if (c == 13) begin
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL held_end: got %b want 0", o_busy); end
      end
      if (o_ie === 1'b1) ie_cnt++;
      next_cycle();
    end
    n_cmp++; if (ie_cnt !== 2) begin n_bad++; $display("FAIL held_ie_count: got %0d want 2", ie_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_min_latency();
    test_delayed();
    test_cpu_we();
    test_timeout();
    test_reset_mid();
    test_miss_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m_cache_refill.md
M_CACHE_REFILL -- requirements
Module: m_cache_refill

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles waiting for any single memory response before abort.
REQ-002 i_clk  input  1  clock; all state updates on posedge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_miss  input  1  refill request from cache controller; sampled in IDLE only.
REQ-005 i_maddr  input  `EADDR_WIDTH  miss address; 4 lsb ignored.
REQ-006 i_cpu_we  input  1  cache 32-bit write in progress; install forbidden while high.
REQ-007 o_busy  output  1  refill in progress (any state but IDLE).
REQ-008 o_mem_req  output  1  memory read request valid.
REQ-009 o_mem_addr  output  `EADDR_WIDTH  word address of current request.
REQ-010 i_mem_gnt  input  1  memory accepts request this cycle.
REQ-011 i_mem_rvalid  input  1  read data valid, in-order.
REQ-012 i_mem_rdata  input  32  read data word.
REQ-013 o_ie  output  1  cache install enable, one-cycle pulse.
REQ-014 o_iaddr  output  `EADDR_WIDTH  install address, 4 lsb zero.
REQ-015 o_idata  output  128  install line, word k in bits [k*32 +: 32].
REQ-016 o_done  output  1  one-cycle pulse: refill finished (install or abort).
REQ-017 o_err  output  1  one-cycle pulse with o_done when aborted by timeout.

Function
REQ-018 States: IDLE, FETCH, DRAIN, INSTALL; fixed encoding in shared package.
REQ-019 IDLE: on i_miss=1, latch line base = {i_maddr[msb:4],4'b0}, clear counters, go FETCH next cycle.
REQ-020 FETCH: o_mem_req=1, o_mem_addr = base + 4*issue_cnt; issue_cnt increments on i_mem_gnt; after 4th grant go DRAIN.
REQ-021 Responses accepted in FETCH and DRAIN; word written to line slot recv_cnt, recv_cnt increments on i_mem_rvalid.
REQ-022 Grant and response in the same cycle both take effect.
REQ-023 i_mem_rvalid when recv_cnt would exceed issue_cnt, or in IDLE/INSTALL, is ignored.
REQ-024 After 4th response (FETCH or DRAIN) go INSTALL; o_mem_req deasserts same cycle the 4th grant is seen.
REQ-025 INSTALL: o_ie=1 only when i_cpu_we=0; o_iaddr=base, o_idata=assembled line; same cycle o_done=1, next state IDLE.
REQ-026 INSTALL with i_cpu_we=1: hold state and line, o_ie=0, no cycle limit.
REQ-027 Timeout counter resets on each response, on each grant, and on entering FETCH; counts cycles with outstanding or unissued words.
REQ-028 Counter reaching TIMEOUT in FETCH/DRAIN: o_done=1, o_err=1, o_ie stays 0, go IDLE; later stale responses ignored.
REQ-029 i_miss while busy is ignored; no queueing.
REQ-030 Minimum latency: miss sampled cycle 0, install at cycle 5 with single-cycle grant and response.
REQ-031 Counters 3-bit (0..4); address arithmetic wraps modulo 2^`EADDR_WIDTH within line only (no carry past bit 3).

Reset
REQ-032 i_rst_n low: state IDLE, counters 0, line register 0, base 0; all outputs 0 immediately.
REQ-033 Reset mid-refill discards partial line, no install pulse; responses arriving after reset release are ignored.

Structure
REQ-034 Shared package: state encoding, LINE_WORDS=4, WORD_OFFSET_BITS=2, line-base mask; `EADDR macros from define.v.
REQ-035 One sub-module: m_refill_timer (loadable down-counter with expire flag).

Verification
REQ-036 Miss at 0x0000_1234, grant and rvalid every cycle, data 0xA0..0xA3 -> o_ie at cycle 5, o_iaddr 0x0000_1230, o_idata {A3,A2,A1,A0}, o_err 0.
REQ-037 Grants on cycles 1,3,5,7, responses delayed 3 cycles -> addresses 0x..30,34,38,3C in order; single install with correct line.
REQ-038 i_cpu_we high 6 cycles in INSTALL -> o_ie delayed until first cycle i_cpu_we=0; line unchanged.
REQ-039 TIMEOUT=8, 3 responses then none -> o_done and o_err pulse at 8th idle cycle, no o_ie; next miss refills correctly.
REQ-040 Assert i_rst_n low after 2 responses -> outputs 0 async, no install; later stale rvalid ignored.
REQ-041 i_miss held high during busy -> exactly one refill per IDLE entry.
